// File: rtl/unsign_multiplier_seq_pkg.sv
// Shared definitions for the sequential unsigned multiply-accumulate unit:
// the FSM state encoding and the bit-counter width helper.
`ifndef UNSIGN_MULTIPLIER_SEQ_PKG_SV
`define UNSIGN_MULTIPLIER_SEQ_PKG_SV

package unsign_multiplier_seq_pkg;

  // Two-bit state code. Code 3 is illegal and falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the multiplier-bit counter. It must index bits 0..w-1,
  // and it is never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`endif

// File: rtl/unsign_multiplier_seq_if.sv
// Start/Busy/Done handshake bundle for the sequential multiply-accumulate unit.
// The master side issues requests and the slave side is the arithmetic unit.
`ifndef UNSIGN_MULTIPLIER_SEQ_IF_SV
`define UNSIGN_MULTIPLIER_SEQ_IF_SV

interface unsign_multiplier_seq_if #(
  parameter int INPUT_BIT_WIDTH = 8
);

  logic                           start;
  logic [INPUT_BIT_WIDTH-1:0]     multiplicand;
  logic [INPUT_BIT_WIDTH-1:0]     multiplier;
  logic [INPUT_BIT_WIDTH-1:0]     addend;
  logic                           busy;
  logic                           done;
  logic [2*INPUT_BIT_WIDTH-1:0]   product;
  logic                           overflow;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product, overflow
  );

endinterface

`endif

// File: rtl/unsign_multiplier_seq.sv
// Sequential unsigned multiply-accumulate: product = a * b + c.
// This is radix-2 shift-add, and one multiplier bit is consumed per clock.
// The latency is fixed: a request accepted on edge k raises done in the cycle
// after edge k+W. done lasts one cycle, and during it a new request can be
// accepted without a bubble.
`ifndef UNSIGN_MULTIPLIER_SEQ_SV
`define UNSIGN_MULTIPLIER_SEQ_SV

module unsign_multiplier_seq
  import unsign_multiplier_seq_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unsign_multiplier_seq_if.slave  bus
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t          state_reg,    state_next;
  logic [W-1:0]    a_reg,        a_next;
  logic [W-1:0]    b_reg,        b_next;
  logic [2*W-1:0]  acc_reg,      acc_next;
  logic [CW-1:0]   cnt_reg,      cnt_next;
  logic            busy_reg,     busy_next;
  logic            done_reg,     done_next;
  logic [2*W-1:0]  product_reg,  product_next;
  logic            overflow_reg, overflow_next;

  // Shift-add step for the current counter position. The accumulator is 2W
  // bits wide. The largest result, (2^W-1)^2 + (2^W-1), stays below 2^2W,
  // so the sum can never wrap.
  logic [2*W-1:0]  partial;
  logic [2*W-1:0]  acc_sum;

  // The addend is zero-extended into the accumulator when a request is
  // accepted, so it is added exactly once.
  logic [2*W-1:0]  addend_ext;

  assign addend_ext = {{W{1'b0}}, bus.addend};
  assign partial    = b_reg[cnt_reg] ? ({{W{1'b0}}, a_reg} << cnt_reg) : '0;
  assign acc_sum    = acc_reg + partial;

  // State register plus datapath registers. An asynchronous reset aborts any
  // computation in flight and clears the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      product_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      product_reg  <= product_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state and datapath control. Registers hold by default. busy and
  // done are recomputed every cycle. product and overflow change only on
  // the final RUN step.
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    product_next  = product_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // Accept a new request. From DONE this gives back-to-back
        // operation. Without a request, DONE falls back to IDLE.
        if (bus.start) begin
          a_next     = bus.multiplicand;
          b_next     = bus.multiplier;
          acc_next   = addend_ext;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        // One multiplier bit per clock. start and operand changes are
        // ignored here, because the operands were latched on acceptance.
        acc_next  = acc_sum;
        cnt_next  = cnt_reg + CW'(1);
        busy_next = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          product_next  = acc_sum;
          overflow_next = |acc_sum[2*W-1:W];
          done_next     = 1'b1;
          busy_next     = 1'b0;
          state_next    = ST_DONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.product  = product_reg;
  assign bus.overflow = overflow_reg;

endmodule

`endif

// File: tb/tb_unsign_multiplier_seq.sv
// Directed bench for the sequential multiply-accumulate unit (W=8).
// Inputs are driven on the falling edge or just after the rising edge.
// Outputs are sampled on the falling edge.
module tb_unsign_multiplier_seq;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  unsign_multiplier_seq_if #(.INPUT_BIT_WIDTH(W)) bus ();

  unsign_multiplier_seq #(.INPUT_BIT_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. It counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request as a single-cycle start pulse, then wait for done.
  // lat counts rising edges after the accepting edge until done is seen.
  // bcnt counts sampled cycles in which busy was high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = e;
        break;
      end
      @(posedge clk);
    end
    check("done_seen", 64'(bus.done), 64'(1));
    $display("[TB] op a=%0d b=%0d c=%0d -> product=%0d ovf=%0b lat=%0d busy_cycles=%0d",
             a, b, c, bus.product, bus.overflow, lat, bcnt);
  endtask

  // Operand sets for the back-to-back run, with hand-computed results.
  logic [W-1:0]   job_a [4] = '{8'd7,   8'd200,   8'd1, 8'd15};
  logic [W-1:0]   job_b [4] = '{8'd9,   8'd100,   8'd1, 8'd17};
  logic [W-1:0]   job_c [4] = '{8'd3,   8'd50,    8'd0, 8'd255};
  logic [2*W-1:0] job_p [4] = '{16'd66, 16'd20050, 16'd1, 16'd510};
  logic           job_o [4] = '{1'b0,   1'b1,     1'b0, 1'b1};

  initial begin
    int lat, bcnt;
    int cyc, last_cyc, njob, done_cnt;
    logic [W-1:0] dd, dv, q, r;

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy",     64'(bus.busy),     64'(0));
    check("rst_done",     64'(bus.done),     64'(0));
    check("rst_product",  64'(bus.product),  64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
    rst_n = 1'b1;

    // Test 1: 13*11+5 = 148. done arrives W edges after the accepting edge.
    run_op(8'd13, 8'd11, 8'd5, lat, bcnt);
    check("t1_product",  64'(bus.product),  64'(148));
    check("t1_overflow", 64'(bus.overflow), 64'(0));
    check("t1_latency",  64'(lat),          64'(W));
    check("t1_busy_cyc", 64'(bcnt),         64'(W));
    check("t1_busy_at_done", 64'(bus.busy), 64'(0));
    @(negedge clk);
    check("t1_done_pulse", 64'(bus.done), 64'(0));

    // Test 2: the maximum case, then all zeros with the same latency.
    run_op(8'd255, 8'd255, 8'd255, lat, bcnt);
    check("t2_max_product",  64'(bus.product),  64'(16'hFF00));
    check("t2_max_overflow", 64'(bus.overflow), 64'(1));
    run_op(8'd0, 8'd200, 8'd0, lat, bcnt);
    check("t2_zero_product",  64'(bus.product),  64'(0));
    check("t2_zero_overflow", 64'(bus.overflow), 64'(0));
    check("t2_zero_latency",  64'(lat),          64'(W));

    // Test 3: divider round trip. quotient * divisor + remainder == dividend.
    for (int i = 0; i < 1000; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(1, 255));
      q  = dd / dv;
      r  = dd % dv;
      run_op(q, dv, r, lat, bcnt);
      check("t3_roundtrip", 64'(bus.product),  64'(dd));
      check("t3_overflow",  64'(bus.overflow), 64'(0));
    end

    // Test 4: start held high. Garbage operands are driven during RUN.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = job_a[0];
    bus.multiplier   = job_b[0];
    bus.addend       = job_c[0];
    cyc      = 0;
    last_cyc = 0;
    njob     = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        check("t4_product",  64'(bus.product),  64'(job_p[njob]));
        check("t4_overflow", 64'(bus.overflow), 64'(job_o[njob]));
        if (njob > 0) check("t4_done_gap", 64'(cyc - last_cyc), 64'(W + 1));
        $display("[TB] b2b job=%0d product=%0d ovf=%0b cycle=%0d", njob, bus.product, bus.overflow, cyc);
        last_cyc = cyc;
        njob++;
        if (njob == 4) break;
        bus.multiplicand = job_a[njob];
        bus.multiplier   = job_b[njob];
        bus.addend       = job_c[njob];
      end else begin
        bus.multiplicand = 8'd99;
        bus.multiplier   = 8'd99;
        bus.addend       = 8'd99;
      end
    end
    check("t4_jobs", 64'(njob), 64'(4));
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Test 5: asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 8'd200;
    bus.multiplier   = 8'd200;
    bus.addend       = 8'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy",     64'(bus.busy),     64'(0));
    check("t5_done",     64'(bus.done),     64'(0));
    check("t5_product",  64'(bus.product),  64'(0));
    check("t5_overflow", 64'(bus.overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("t5_no_done", 64'(done_cnt), 64'(0));
    run_op(8'd3, 8'd4, 8'd1, lat, bcnt);
    check("t5_after_product", 64'(bus.product), 64'(13));

    // Test 6: outputs hold while operands toggle with start low.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.multiplicand = 8'($urandom);
      bus.multiplier   = 8'($urandom);
      bus.addend       = 8'($urandom);
      check("t6_product",  64'(bus.product),  64'(13));
      check("t6_overflow", 64'(bus.overflow), 64'(0));
      check("t6_done",     64'(bus.done),     64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
